// File: rtl/lsm_pkg.sv
// rtl/lsm_pkg.sv - shared LSM pipeline defaults, accumulator FSM states and saturation helper
package lsm_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int QFRAC_DEF = 16;
  localparam int SAT_W     = 128;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } acc_state_t;

  typedef struct packed {
    logic                        ovf;
    logic signed [WIDTH_DEF-1:0] val;
  } sat_res_t;

  // Clamp a wide signed value into a w-bit signed range (w <= WIDTH_DEF).
  function automatic sat_res_t sat_to_width(input logic signed [SAT_W-1:0] acc,
                                            input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] clamped;
    sat_res_t                r;
    hi      = {{(SAT_W-1){1'b0}}, 1'b1};
    hi      = (hi <<< (w - 1)) - {{(SAT_W-1){1'b0}}, 1'b1};
    lo      = ~hi;
    clamped = acc;
    r.ovf   = 1'b0;
    if (acc > hi) begin
      clamped = hi;
      r.ovf   = 1'b1;
    end else if (acc < lo) begin
      clamped = lo;
      r.ovf   = 1'b1;
    end
    r.val = clamped[WIDTH_DEF-1:0];
    return r;
  endfunction

endpackage

// File: rtl/lsm_sq_pipe.sv
// rtl/lsm_sq_pipe.sv - one-stage registered signed squarer, result scaled back by QFRAC
module lsm_sq_pipe
  import lsm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int QFRAC = QFRAC_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_tvalid,
  input  logic [WIDTH-1:0]            in_tdata,
  output logic                        out_tvalid,
  output logic signed [2*WIDTH-1:0]   out_tdata
);

  logic signed [2*WIDTH-1:0] ext;
  logic signed [2*WIDTH-1:0] prod;

  assign ext  = {{WIDTH{in_tdata[WIDTH-1]}}, in_tdata};
  assign prod = ext * ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
    end else begin
      out_tvalid <= in_tvalid;
      if (in_tvalid) begin
        out_tdata <= prod >>> QFRAC;
      end
    end
  end

endmodule

// File: rtl/lsm_pv_accumulator.sv
// rtl/lsm_pv_accumulator.sv - per-batch mean PV and mean PV^2 accumulator for the LSM pipeline
module lsm_pv_accumulator
  import lsm_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int QINT       = 16,
  parameter int QFRAC      = QFRAC_DEF,
  parameter int NPATH_LOG2 = 10,
  parameter int ACC_WIDTH  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] PV_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] price,
  output logic [WIDTH-1:0] second_moment,
  output logic [1:0]       status,
  output logic [15:0]      batch_id
);

  if (QINT + QFRAC != WIDTH || WIDTH > WIDTH_DEF || NPATH_LOG2 < 1 || NPATH_LOG2 > 20 ||
      ACC_WIDTH < 2*WIDTH - QFRAC + NPATH_LOG2 + 1 || ACC_WIDTH > SAT_W) begin : g_bad_params
    $error("lsm_pv_accumulator: illegal parameter set");
  end

  acc_state_t                state_q, state_d;
  logic signed [ACC_WIDTH-1:0] sum_acc, sq_acc;
  logic [NPATH_LOG2-1:0]     count;
  logic                      neg_seen;
  logic                      accept, last_accept, handshake;
  logic                      sq_valid;
  logic signed [2*WIDTH-1:0] sq_data;
  sat_res_t                  sat_p, sat_s;

  assign ready_out   = (state_q == ACCUM) && !rst;
  assign valid_out   = (state_q == DONE);
  assign accept      = valid_in && ready_out;
  assign handshake   = valid_out && ready_in;
  assign last_accept = accept && (count == {NPATH_LOG2{1'b1}});

  assign sat_p = sat_to_width(SAT_W'(sum_acc >>> NPATH_LOG2), WIDTH);
  assign sat_s = sat_to_width(SAT_W'(sq_acc >>> NPATH_LOG2), WIDTH);

  lsm_sq_pipe #(
    .WIDTH (WIDTH),
    .QFRAC (QFRAC)
  ) u_sq_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_tvalid  (accept),
    .in_tdata   (PV_in),
    .out_tvalid (sq_valid),
    .out_tdata  (sq_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (last_accept) state_d = DRAIN;
      DRAIN:   state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (handshake) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACCUM;
      sum_acc       <= '0;
      sq_acc        <= '0;
      count         <= '0;
      neg_seen      <= 1'b0;
      price         <= '0;
      second_moment <= '0;
      status        <= '0;
      batch_id      <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        sum_acc  <= '0;
        sq_acc   <= '0;
        count    <= '0;
        neg_seen <= 1'b0;
        batch_id <= batch_id + 16'd1;
      end else begin
        if (accept) begin
          sum_acc <= sum_acc + ACC_WIDTH'($signed(PV_in));
          count   <= count + NPATH_LOG2'(1);
          if (PV_in[WIDTH-1]) neg_seen <= 1'b1;
        end
        // The square lags its accept by one cycle; DRAIN exists to catch the last one.
        if (sq_valid) sq_acc <= sq_acc + ACC_WIDTH'(sq_data);
      end
      if (state_q == FINAL) begin
        price         <= sat_p.val[WIDTH-1:0];
        second_moment <= sat_s.val[WIDTH-1:0];
        status        <= {neg_seen, sat_p.ovf | sat_s.ovf};
      end
    end
  end

endmodule
